// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the instruction-fetch sequencer: FSM state
//   encoding, default bus widths, branch offset width and the PC value the
//   PC module loads when reset_pc is asserted.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int INSTR_W_DEF    = 16;     // instruction word width
  localparam int ADDR_W_DEF     = 15;     // PC / instruction address width
  localparam int OFFSET_W       = 4;      // unsigned branch offset width
  localparam int TIMEOUT_DEF    = 255;    // WAIT cycles before a fetch fault
  localparam int TIMEOUT_CNT_W  = 16;     // holds any TIMEOUT in 1..65535
  localparam int PC_RESET_VALUE = 1;      // PC after a reset_pc request

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,  // reset_pc asserted, nothing in flight
    ST_REQ   = 3'd1,  // one-cycle memory read strobe
    ST_WAIT  = 3'd2,  // waiting for mem_rd_valid, timeout running
    ST_HOLD  = 3'd3,  // instruction presented to the decoder
    ST_STEP  = 3'd4,  // one-cycle PC increment or branch pulse
    ST_IDLE  = 3'd5,  // halted between instructions
    ST_FAULT = 3'd6   // memory timeout, left only by reset
  } state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
//   Counts WAIT cycles of an outstanding instruction read. The count is
//   loaded with zero by i_clear and advances by one on every enabled edge,
//   saturating at TIMEOUT. o_expired is high while the count equals TIMEOUT.
//
// Ports
//   clk        in   system clock, rising edge
//   i_clear    in   synchronous clear (wins over i_enable)
//   i_enable   in   advance the count this edge
//   o_expired  out  count == TIMEOUT
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  assign w_expired = (r_count == CNT_W'(TIMEOUT));

  // NOTE: sequential state is written with <= so every register in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = w_expired;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch controller. Reads instruction memory at the current PC,
//   holds the word for the decoder under valid/ready, then steps the PC by +1
//   or by a 4-bit unsigned branch offset through one-cycle pulses to the PC
//   module. A read that is not answered within TIMEOUT WAIT cycles parks the
//   sequencer in a sticky fault state until reset_fetch.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_fetch    in   synchronous active-high reset
//   PC_pointer     in   current PC from the PC module
//   incr_PC        out  one-cycle pulse: PC <= PC + 1
//   branch_offset  out  one-cycle pulse: PC <= PC + offset_value
//   offset_value   out  branch offset, valid with branch_offset
//   reset_pc       out  PC reset request (PC <= 1)
//   mem_rd_en      out  instruction memory read strobe
//   mem_addr       out  read address
//   mem_rd_valid   in   read data valid (honoured in WAIT only)
//   mem_rd_data    in   read data
//   instr_valid    out  instruction available to the decoder
//   instr          out  fetched instruction
//   instr_pc       out  PC of the fetched instruction
//   instr_ready    in   decoder accepts the instruction
//   take_branch    in   sampled on accept: branch instead of increment
//   branch_off_in  in   sampled on accept together with take_branch
//   halt           in   stop fetching after the current instruction
//   fetch_fault    out  sticky memory-timeout flag
//   fetch_count    out  accepted instruction count, wraps at 16 bits
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_fetch,
  input  logic [ADDR_W-1:0]   PC_pointer,
  output logic                incr_PC,
  output logic                branch_offset,
  output logic [OFFSET_W-1:0] offset_value,
  output logic                reset_pc,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_rd_valid,
  input  logic [INSTR_W-1:0]  mem_rd_data,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready,
  input  logic                take_branch,
  input  logic [OFFSET_W-1:0] branch_off_in,
  input  logic                halt,
  output logic                fetch_fault,
  output logic [15:0]         fetch_count
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_next_state;

  logic                r_reset_pc;
  logic                r_incr_pc;
  logic                r_branch_offset;
  logic [OFFSET_W-1:0] r_offset_value;
  logic                r_mem_rd_en;
  logic                r_instr_valid;
  logic                r_fetch_fault;
  logic [INSTR_W-1:0]  r_instr;
  logic [ADDR_W-1:0]   r_instr_pc;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [15:0]         r_fetch_count;

  logic                w_reset_pc_d;
  logic                w_incr_pc_d;
  logic                w_branch_offset_d;
  logic [OFFSET_W-1:0] w_offset_value_d;
  logic                w_mem_rd_en_d;
  logic                w_instr_valid_d;
  logic                w_fetch_fault_d;

  logic                w_accept;
  logic                w_rsp_take;
  logic                w_tmo_clear;
  logic                w_tmo_enable;
  logic                w_tmo_expired;

  assign w_accept   = (r_state == ST_HOLD) && instr_ready;
  assign w_rsp_take = (r_state == ST_WAIT) && mem_rd_valid;

  // ---------------------------------------------------------------------------
  // Timeout counter. It is zero during REQ and advances on the edge into each
  // WAIT cycle, so during the k-th WAIT cycle it reads k. A response is still
  // accepted in the TIMEOUT-th WAIT cycle; without one the FSM faults there.
  // ---------------------------------------------------------------------------
  assign w_tmo_clear  = reset_fetch || (w_next_state == ST_REQ);
  assign w_tmo_enable = (w_next_state == ST_WAIT);

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (TIMEOUT_CNT_W)
  ) u_timeout (
    .clk       (clk),
    .i_clear   (w_tmo_clear),
    .i_enable  (w_tmo_enable),
    .o_expired (w_tmo_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_fetch) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment ahead of the case keeps this block purely
  // combinational; without it an unlisted path would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RST:   w_next_state = ST_REQ;
      ST_REQ:   w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (mem_rd_valid) begin
          w_next_state = ST_HOLD;
        end else if (w_tmo_expired) begin
          w_next_state = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          w_next_state = ST_STEP;
        end
      end
      // halt is only looked at here, so an instruction already in flight
      // always completes its STEP.
      ST_STEP:  w_next_state = halt ? ST_IDLE : ST_REQ;
      ST_IDLE: begin
        if (!halt) begin
          w_next_state = ST_REQ;
        end
      end
      ST_FAULT: w_next_state = ST_FAULT;
      default:  w_next_state = ST_RST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output decode. Outputs are decoded from the next state and
  // registered, so each strobe is high exactly for the cycles the FSM spends
  // in the matching state. STEP is only entered from an accept in HOLD, so
  // take_branch/branch_off_in are sampled on that accept edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_reset_pc_d      = (w_next_state == ST_RST);
    w_mem_rd_en_d     = (w_next_state == ST_REQ);
    w_instr_valid_d   = (w_next_state == ST_HOLD);
    w_fetch_fault_d   = (w_next_state == ST_FAULT);
    w_incr_pc_d       = (w_next_state == ST_STEP) && !take_branch;
    w_branch_offset_d = (w_next_state == ST_STEP) &&  take_branch;
    w_offset_value_d  = w_branch_offset_d ? branch_off_in : '0;
  end

  always_ff @(posedge clk) begin
    if (reset_fetch) begin
      r_reset_pc      <= 1'b1;
      r_mem_rd_en     <= 1'b0;
      r_instr_valid   <= 1'b0;
      r_fetch_fault   <= 1'b0;
      r_incr_pc       <= 1'b0;
      r_branch_offset <= 1'b0;
      r_offset_value  <= '0;
    end else begin
      r_reset_pc      <= w_reset_pc_d;
      r_mem_rd_en     <= w_mem_rd_en_d;
      r_instr_valid   <= w_instr_valid_d;
      r_fetch_fault   <= w_fetch_fault_d;
      r_incr_pc       <= w_incr_pc_d;
      r_branch_offset <= w_branch_offset_d;
      r_offset_value  <= w_offset_value_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: request address, fetched word and accept counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_fetch) begin
      r_req_addr    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      if (r_state == ST_REQ) begin
        r_req_addr <= PC_pointer;
      end
      if (w_rsp_take) begin
        r_instr    <= mem_rd_data;
        r_instr_pc <= r_req_addr;
      end
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The PC module updates PC_pointer on the same edge that enters
  // REQ, so a locally registered copy would be one fetch stale; the address
  // is the PC module's own register, gated by the registered read strobe.
  // ---------------------------------------------------------------------------
  assign mem_addr      = r_mem_rd_en ? PC_pointer : '0;
  assign mem_rd_en     = r_mem_rd_en;
  assign reset_pc      = r_reset_pc;
  assign incr_PC       = r_incr_pc;
  assign branch_offset = r_branch_offset;
  assign offset_value  = r_offset_value;
  assign instr_valid   = r_instr_valid;
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign fetch_fault   = r_fetch_fault;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Bench for fetch_sequencer with TIMEOUT=8. Contains a behavioural PC module
//   and a fixed-latency instruction memory. Expected fetch addresses go into a
//   queue when the decoder-side stimulus is driven and are popped whenever the
//   DUT raises mem_rd_en. Instruction-level vectors come from a table; timeout,
//   halt and mid-operation reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int AW  = 15;
  localparam int IW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset_fetch;
  logic [AW-1:0] pc_model;
  logic          incr_PC;
  logic          branch_offset;
  logic [3:0]    offset_value;
  logic          reset_pc;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_valid;
  logic [IW-1:0] mem_rd_data;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          take_branch;
  logic [3:0]    branch_off_in;
  logic          halt;
  logic          fetch_fault;
  logic [15:0]   fetch_count;

  // memory model state
  logic          mem_respond;
  int            mem_latency;
  int            mem_pending;
  logic [AW-1:0] mem_req_addr;
  logic          mem_valid_m;
  logic [IW-1:0] mem_data_m;
  logic          stray_valid;

  int            n_total;
  int            n_pass;
  int            cyc;
  int            exp_count;
  int            prev_step;
  int            step_cyc;
  logic [AW-1:0] exp_addr_q[$];

  typedef struct {
    logic          tb;      // take_branch on accept
    logic [3:0]    off;     // branch_off_in on accept
    int            delay;   // HOLD cycles with instr_ready low
    logic [AW-1:0] pc;      // expected instr_pc
    logic [AW-1:0] nxt;     // expected next fetch address
    logic          chk_gap; // PC pulse must be 4 cycles after the previous
  } vec_t;

  vec_t vecs[7];

  fetch_sequencer #(
    .INSTR_W (IW),
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset_fetch   (reset_fetch),
    .PC_pointer    (pc_model),
    .incr_PC       (incr_PC),
    .branch_offset (branch_offset),
    .offset_value  (offset_value),
    .reset_pc      (reset_pc),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .take_branch   (take_branch),
    .branch_off_in (branch_off_in),
    .halt          (halt),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PC module: 15-bit, wraps, zero-extended branch offset.
  always @(posedge clk) begin
    if (reset_pc)           pc_model <= AW'(PC_RESET_VALUE);
    else if (incr_PC)       pc_model <= pc_model + 15'd1;
    else if (branch_offset) pc_model <= pc_model + {11'd0, offset_value};
  end

  function automatic logic [IW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 15'd3) ? 16'hBEEF : ({1'b0, a} ^ 16'hA5C3);
  endfunction

  // Instruction memory: answers mem_latency cycles after the REQ cycle.
  always @(posedge clk) begin
    #1;
    mem_valid_m = 1'b0;
    if (mem_pending > 0) begin
      mem_pending = mem_pending - 1;
      if (mem_pending == 0) begin
        mem_valid_m = 1'b1;
        mem_data_m  = mem_fn(mem_req_addr);
      end
    end
    if (mem_respond && mem_rd_en) begin
      mem_pending  = mem_latency;
      mem_req_addr = mem_addr;
    end
  end

  assign mem_rd_valid = mem_valid_m | stray_valid;
  assign mem_rd_data  = stray_valid ? 16'hDEAD : mem_data_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Scoreboard: every read strobe must match the next expected address.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected mem_rd_en, mem_addr", {17'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("mem_addr", {17'd0, mem_addr}, {17'd0, exp_addr_q.pop_front()});
      end
    end
  end

  // One instruction: wait for HOLD, optionally stall, accept, check STEP.
  task automatic do_instr(input vec_t v, input logic halt_in_hold, input logic push_next,
                          output int step_at);
    int n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("instr_valid arrives", instr_valid, 1);
    check("instr_pc", instr_pc, v.pc);
    check("instr", instr, mem_fn(v.pc));
    if (halt_in_hold) halt = 1'b1;
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      check("stall instr_valid", instr_valid, 1);
      check("stall instr", instr, mem_fn(v.pc));
      check("stall instr_pc", instr_pc, v.pc);
      check("stall PC pulses", {incr_PC, branch_offset}, 0);
    end
    instr_ready   = 1'b1;
    take_branch   = v.tb;
    branch_off_in = v.off;
    exp_count++;
    if (push_next) exp_addr_q.push_back(v.nxt);
    @(negedge clk);
    instr_ready   = 1'b0;
    take_branch   = 1'b0;
    branch_off_in = 4'd0;
    step_at = cyc;
    check("STEP incr_PC", incr_PC, !v.tb);
    check("STEP branch_offset", branch_offset, v.tb);
    check("STEP offset_value", offset_value, v.tb ? v.off : 4'd0);
    check("STEP instr_valid", instr_valid, 0);
    check("fetch_count", fetch_count, exp_count[15:0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    n_total = 0; n_pass = 0; cyc = 0; exp_count = 0; prev_step = 0;
    pc_model = 15'h1234;
    reset_fetch = 1'b1; instr_ready = 1'b0; take_branch = 1'b0;
    branch_off_in = 4'd0; halt = 1'b0; stray_valid = 1'b0;
    mem_respond = 1'b1; mem_latency = 1; mem_pending = 0;
    mem_valid_m = 1'b0; mem_data_m = '0; mem_req_addr = '0;

    //                 tb    off    dly pc      next    gap
    vecs[0] = '{1'b0, 4'h0, 0, 15'd1,  15'd2,  1'b0};
    vecs[1] = '{1'b0, 4'h0, 0, 15'd2,  15'd3,  1'b1};
    vecs[2] = '{1'b0, 4'h0, 6, 15'd3,  15'd4,  1'b0}; // backpressure on BEEF
    vecs[3] = '{1'b0, 4'h0, 0, 15'd4,  15'd5,  1'b0};
    vecs[4] = '{1'b1, 4'hA, 0, 15'd5,  15'd15, 1'b1}; // branch +10
    vecs[5] = '{1'b1, 4'h0, 0, 15'd15, 15'd15, 1'b0}; // offset 0 re-fetches
    vecs[6] = '{1'b0, 4'h0, 0, 15'd15, 15'd16, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset reset_pc", reset_pc, 1);
    check("reset mem_rd_en", mem_rd_en, 0);
    check("reset PC pulses", {incr_PC, branch_offset}, 0);
    check("reset offset_value", offset_value, 0);
    check("reset instr_valid", instr_valid, 0);
    check("reset instr", instr, 0);
    check("reset instr_pc", instr_pc, 0);
    check("reset fetch_fault", fetch_fault, 0);
    check("reset fetch_count", fetch_count, 0);
    exp_addr_q.push_back(AW'(PC_RESET_VALUE));
    reset_fetch = 1'b0;

    // Table-driven free run, backpressure and branches
    for (int i = 0; i < 7; i++) begin
      do_instr(vecs[i], 1'b0, 1'b1, step_cyc);
      if (vecs[i].chk_gap) check("PC pulse spacing", step_cyc - prev_step, 4);
      prev_step = step_cyc;
      if (i == 3) check("fetch_count after 4 accepts", fetch_count, 16'd4);
    end

    // Timeout: memory stops answering from the fetch at 16
    mem_respond = 1'b0;
    @(negedge clk);                       // REQ at 16
    n = 0;
    while (!fetch_fault && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cycles from REQ to fetch_fault", n, TMO + 1);
    stray_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fault sticky", fetch_fault, 1);
      check("fault instr_valid", instr_valid, 0);
      check("fault strobes", {mem_rd_en, incr_PC, branch_offset, reset_pc}, 0);
      check("fault fetch_count", fetch_count, exp_count[15:0]);
    end
    stray_valid = 1'b0;
    reset_fetch = 1'b1;
    mem_respond = 1'b1;
    @(negedge clk);
    check("reset clears fetch_fault", fetch_fault, 0);
    check("reset reasserts reset_pc", reset_pc, 1);
    check("reset clears fetch_count", fetch_count, 0);
    exp_count = 0;
    exp_addr_q.push_back(15'd1);
    reset_fetch = 1'b0;

    // Halt at PC=7: reach it with a branch of +6 from 1
    do_instr('{1'b1, 4'h6, 0, 15'd1, 15'd7, 1'b0}, 1'b0, 1'b1, step_cyc);
    do_instr('{1'b0, 4'h0, 0, 15'd7, 15'd8, 1'b0}, 1'b1, 1'b0, step_cyc);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("IDLE strobes", {mem_rd_en, incr_PC, branch_offset, instr_valid}, 0);
    end
    halt = 1'b0;
    exp_addr_q.push_back(15'd8);

    // Mid-operation reset during WAIT, stray response right after release
    mem_respond = 1'b0;
    @(negedge clk);                       // REQ at 8
    @(negedge clk);                       // WAIT
    reset_fetch = 1'b1;
    @(negedge clk);                       // RST
    check("mid reset reset_pc", reset_pc, 1);
    check("mid reset instr_valid", instr_valid, 0);
    check("mid reset fetch_count", fetch_count, 0);
    check("mid reset mem_rd_en", mem_rd_en, 0);
    exp_count = 0;
    exp_addr_q.push_back(15'd1);
    reset_fetch = 1'b0;
    mem_respond = 1'b1;
    stray_valid = 1'b1;
    @(posedge clk); #1;                   // REQ cycle, stray still high
    @(posedge clk); #1;                   // WAIT cycle, real response
    stray_valid = 1'b0;
    do_instr('{1'b0, 4'h0, 0, 15'd1, 15'd2, 1'b0}, 1'b0, 1'b1, step_cyc);
    @(negedge clk);                       // REQ at 2
    @(negedge clk);
    check("scoreboard drained", exp_addr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that drives the PC module's control inputs and consumes its PC_pointer output.
- Each cycle of operation: reads instruction memory at the current PC, holds the word for the decode stage under valid/ready, then steps the PC by +1 or by a 4-bit branch offset.
- Sits between the PC module, the instruction memory and the decoder; the only block that drives incr_PC, branch_offset, offset_value and reset_pc.

Parameters:
- INSTR_W, 16, instruction word width.
- ADDR_W, 15, PC/address width; matches PC_pointer.
- TIMEOUT, 255, maximum WAIT cycles before a fetch fault; 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset_fetch  in  1  synchronous, active-high reset.
- PC_pointer  in  ADDR_W  current PC from the PC module.
- incr_PC  out  1  one-cycle pulse: PC <= PC+1.
- branch_offset  out  1  one-cycle pulse: PC <= PC+offset_value.
- offset_value  out  4  branch offset, unsigned, held valid with branch_offset.
- reset_pc  out  1  PC reset request (PC <= 1).
- mem_rd_en  out  1  instruction memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_valid  in  1  read data valid.
- mem_rd_data  in  INSTR_W  read data.
- instr_valid  out  1  instruction available to decoder.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  PC of the fetched instruction.
- instr_ready  in  1  decoder accepts instruction.
- take_branch  in  1  sampled on accept: branch instead of increment.
- branch_off_in  in  4  sampled on accept with take_branch.
- halt  in  1  stop fetching after the current instruction.
- fetch_fault  out  1  sticky memory-timeout flag.
- fetch_count  out  16  count of accepted instructions, wraps.

Behaviour:
- All outputs are registered.
- Reset values while reset_fetch=1: state RST, reset_pc=1, every other output 0, instr/instr_pc/fetch_count cleared, timeout counter 0.
- FSM states: RST, REQ, WAIT, HOLD, STEP, IDLE, FAULT.
- RST -> REQ on the first edge after reset is released. reset_pc drops on that edge; the PC module sees reset_pc=1 on the same edge and loads PC=1, so REQ always sees PC_pointer=1.
- REQ: mem_rd_en=1 and mem_addr=PC_pointer for exactly one cycle -> WAIT. Timeout counter is cleared.
- WAIT: on mem_rd_valid, latch instr<=mem_rd_data and instr_pc<=mem_addr -> HOLD. Otherwise the counter increments; when it reaches TIMEOUT -> FAULT.
- mem_rd_valid is ignored in every state except WAIT. The earliest accepted response is the cycle after REQ.
- HOLD: instr_valid=1; instr and instr_pc are stable. On instr_ready=1:
  - sample take_branch and branch_off_in;
  - fetch_count increments, wrapping at 16 bits;
  - -> STEP, with instr_valid low from the STEP cycle.
- STEP, exactly one cycle:
  - take_branch=1: branch_offset=1, offset_value=sampled value.
  - take_branch=0: incr_PC=1, offset_value=0.
  - incr_PC and branch_offset are never high together.
- Leaving STEP: halt=1 -> IDLE; otherwise -> REQ. The PC has updated by the time REQ starts.
- IDLE: all strobes low; -> REQ when halt=0.
- halt has no effect before STEP; an instruction already in flight completes.
- FAULT: fetch_fault=1, all strobes and instr_valid low. Only reset_fetch leaves FAULT.
- Branch arithmetic is done in the PC module: 15-bit unsigned with zero-extended offset, wrapping modulo 2^15. Offset 0 is legal and re-fetches the same address.
- Minimum throughput is 4 cycles per instruction (REQ, WAIT, HOLD, STEP).
- reset_fetch in any state returns to RST on that edge: in-flight data is dropped, instr_valid drops, fetch_fault clears, reset_pc is reasserted.

Decomposition:
- Shared package holds:
  - state encoding enum (RST, REQ, WAIT, HOLD, STEP, IDLE, FAULT);
  - PC_RESET_VALUE=1;
  - ADDR_W/INSTR_W defaults;
  - OFFSET_W=4.
- One natural sub-module, fetch_timeout_counter: clear, enable, count, expired=(count==TIMEOUT).
- The FSM, the registers and the fetch counter stay in the top module.

Test Plan:
- Reset then free-run with memory latency 1, instr_ready=1, take_branch=0:
  - mem_addr sequence 1,2,3,4;
  - one incr_PC pulse per instruction, 4 cycles apart;
  - fetch_count=4 after 4 accepts.
- Branch: at PC=5 accept with take_branch=1, branch_off_in=4'hA:
  - one branch_offset pulse with offset_value=10;
  - next mem_addr=15; incr_PC stays low.
- Backpressure: hold instr_ready=0 for 6 cycles with instr=16'hBEEF at instr_pc=3:
  - instr_valid, instr and instr_pc stable;
  - no PC pulse until the ready cycle.
- Timeout with TIMEOUT=8 and mem_rd_valid never asserted:
  - fetch_fault=1 after 8 WAIT cycles and stays set;
  - stray mem_rd_valid afterwards ignored;
  - reset_fetch clears it and the next fetch is at address 1.
- Halt: raise halt during HOLD at PC=7:
  - STEP pulses incr_PC, then IDLE with no mem_rd_en;
  - deassert halt -> REQ at mem_addr=8.
- Mid-operation reset asserted during WAIT, with mem_rd_valid arriving the cycle after release:
  - response ignored, reset_pc pulses, REQ at mem_addr=1;
  - fetch_count=0, instr_valid=0.
